// File: rtl/conv_window_buffer.sv
// conv_window_buffer: streaming 3x3 sliding-window generator.
//
// Takes one DATA_W-bit pixel per handshake in raster order. The two previous
// image rows are kept in line memories, and the module emits the 3x3
// neighbourhood anchored at the newest pixel.
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   reset     - asynchronous, active-low reset
//   in_valid  - input pixel valid
//   in_ready  - input accept (transfer = in_valid & in_ready)
//   in_sof    - start of frame, qualified by in_valid
//   in_data   - pixel value
//   out_valid - window valid
//   out_ready - downstream accept
//   out_win   - 9 taps; tap k = 3*dr+dc sits at [k*DATA_W +: DATA_W]
//               and holds pixel (r-2+dr, c-2+dc); k=8 is the newest pixel
//   out_last  - window belongs to the last pixel of the frame
//
// Build option:
//   LB_ZERO_PAD_EN - when defined, a window is emitted for every pixel and
//                    out-of-image taps read as 0. When undefined, windows
//                    are emitted only for r>=2 && c>=2.
module conv_window_buffer #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [9*DATA_W-1:0]   out_win,
    output logic                  out_last
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, pc;
    logic [RW-1:0] row_q, row_d, pr;
    logic [DATA_W-1:0] line_a [IMG_W];  // row r-1
    logic [DATA_W-1:0] line_b [IMG_W];  // row r-2
    logic [8:0][DATA_W-1:0] win_q, win_d, win_new;
    logic valid_q, valid_d, last_q, last_d;
    logic accept, emit, at_end;

    always_comb begin
        in_ready = ~valid_q | out_ready;
        accept   = in_valid & in_ready;

        // in_sof overrides the counters so a mid-frame resync lands at (0,0).
        pc     = in_sof ? '0 : col_q;
        pr     = in_sof ? '0 : row_q;
        at_end = (pr == ROW_MAX) && (pc == COL_MAX);

`ifdef LB_ZERO_PAD_EN
        emit = 1'b1;
`else
        emit = (int'(pr) >= 2) && (int'(pc) >= 2);
`endif

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pc == COL_MAX) begin
                col_d = '0;
                row_d = (pr == ROW_MAX) ? '0 : pr + 1'b1;
            end else begin
                col_d = pc + 1'b1;
                row_d = pr;
            end
        end

        // Shift one column left and insert {row r-2, row r-1, row r}.
        win_new = '0;
        for (int dr = 0; dr < 3; dr++) begin
            win_new[3*dr]     = win_q[3*dr+1];
            win_new[3*dr + 1] = win_q[3*dr+2];
        end
        win_new[2] = line_b[pc];
        win_new[5] = line_a[pc];
        win_new[8] = in_data;

        // Zero taps above or left of the image; this also kills the previous
        // row's columns that slide in after a column wrap.
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if ((int'(pr) < 2 - dr) || (int'(pc) < 2 - dc)) begin
                    win_new[3*dr + dc] = '0;
                end
            end
        end

        win_d   = accept ? win_new : win_q;
        valid_d = accept ? emit : (out_ready ? 1'b0 : valid_q);
        last_d  = accept ? (emit & at_end) : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Line memories are not reset; taps that would read stale data are masked.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_b[pc] <= line_a[pc];
            line_a[pc] <= in_data;
        end
    end

    assign out_valid = valid_q;
    assign out_win   = win_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed, table-driven bench for conv_window_buffer (DATA_W=13, 4x4 image).
module tb_conv_window_buffer;

    localparam int DW = 13;
    localparam int WW = 9 * DW;

`ifdef LB_ZERO_PAD_EN
    localparam int NWIN   = 16;
    localparam int NV     = 5;
    localparam int PRE5   = 5;
    localparam int RST_PX = 1;
`else
    localparam int NWIN   = 4;
    localparam int NV     = 4;
    localparam int PRE5   = 0;
    localparam int RST_PX = 11;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_win;
    logic          out_last;

    conv_window_buffer #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      idx;   // position within the frame's emitted windows
        logic [8:0][7:0] t;     // expected taps k0..k8 (frame-1 values)
        logic            last;
    } vec_t;

    vec_t vec [NV];
    logic [WW-1:0] q_win [$];
    logic          q_last [$];
    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            q_win.push_back(out_win);
            q_last.push_back(out_last);
        end
    end

    function automatic logic [8:0][7:0] tp(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        logic [8:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
        r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
        r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8);
        return r;
    endfunction

    function automatic logic [WW-1:0] mkwin(input logic [8:0][7:0] t, input int off);
        logic [WW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            v[k*DW +: DW] = (t[k] == 8'd0) ? 13'd0 : 13'(int'(t[k]) + off);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_px(input int d, input bit sof);
        int n;
        in_valid = 1'b1;
        in_data  = 13'(d);
        in_sof   = sof;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready timeout: got 0 expected 1 for pixel %0d", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int off);
        for (int i = 0; i < 16; i++) send_px(i + 1 + off, i == 0);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int start, input int off, input string tag);
        int idx;
        for (int v = 0; v < NV; v++) begin
            idx = start + int'(vec[v].idx);
            if (idx < q_win.size()) begin
                chk($sformatf("%s win%0d", tag, idx), q_win[idx], mkwin(vec[v].t, off));
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s win%0d: got none expected a window", tag, idx);
            end
        end
        for (int i = 0; i < NWIN; i++) begin
            idx = start + i;
            if (idx < q_last.size()) begin
                chk($sformatf("%s last%0d", tag, idx), WW'(q_last[idx]), WW'(i == NWIN - 1));
            end
        end
    endtask

    task automatic chk_count(input string tag, input int exp);
        chk({tag, " count"}, WW'(q_win.size()), WW'(exp));
    endtask

    initial begin
        logic [WW-1:0] hold;
        int n;

`ifdef LB_ZERO_PAD_EN
        vec[0] = '{idx: 8'd0,  t: tp(0, 0, 0, 0, 0, 0, 0, 0, 1),        last: 1'b0};
        vec[1] = '{idx: 8'd4,  t: tp(0, 0, 0, 0, 0, 1, 0, 0, 5),        last: 1'b0};
        vec[2] = '{idx: 8'd5,  t: tp(0, 0, 0, 0, 1, 2, 0, 5, 6),        last: 1'b0};
        vec[3] = '{idx: 8'd10, t: tp(1, 2, 3, 5, 6, 7, 9, 10, 11),      last: 1'b0};
        vec[4] = '{idx: 8'd15, t: tp(6, 7, 8, 10, 11, 12, 14, 15, 16),  last: 1'b1};
`else
        vec[0] = '{idx: 8'd0, t: tp(1, 2, 3, 5, 6, 7, 9, 10, 11),       last: 1'b0};
        vec[1] = '{idx: 8'd1, t: tp(2, 3, 4, 6, 7, 8, 10, 11, 12),      last: 1'b0};
        vec[2] = '{idx: 8'd2, t: tp(5, 6, 7, 9, 10, 11, 13, 14, 15),    last: 1'b0};
        vec[3] = '{idx: 8'd3, t: tp(6, 7, 8, 10, 11, 12, 14, 15, 16),   last: 1'b1};
`endif

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst out_valid", WW'(out_valid), '0);
        chk("rst out_win", out_win, '0);
        chk("rst out_last", WW'(out_last), '0);
        chk("rst in_ready", WW'(in_ready), WW'(1));
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Case 1: single frame, no backpressure
        q_win.delete(); q_last.delete();
        send_frame(0);
        drain();
        chk_count("c1", NWIN);
        check_frame(0, 0, "c1");

        // Case 3: 5-cycle backpressure on the first window
        q_win.delete(); q_last.delete();
        fork
            send_frame(0);
            begin
                n = 0;
                while (!out_valid && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("c3 stall reached", WW'(out_valid), WW'(1));
                hold = out_win;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("c3 win stable", out_win, hold);
                    chk("c3 in_ready low", WW'(in_ready), '0);
                    chk("c3 valid held", WW'(out_valid), WW'(1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk_count("c3", NWIN);
        check_frame(0, 0, "c3");

        // Case 4: back-to-back frames, second offset by 100
        q_win.delete(); q_last.delete();
        send_frame(0);
        send_frame(100);
        drain();
        chk_count("c4", 2 * NWIN);
        check_frame(0, 0, "c4f1");
        check_frame(NWIN, 100, "c4f2");

        // Case 5: in_sof on the 6th pixel restarts the frame
        q_win.delete(); q_last.delete();
        for (int i = 0; i < 5; i++) send_px(i + 1, i == 0);
        send_frame(0);
        drain();
        chk_count("c5", PRE5 + NWIN);
        check_frame(PRE5, 0, "c5");

        // Case 6: asynchronous reset mid-frame with a window pending
        out_ready = 1'b0;
        for (int i = 0; i < RST_PX; i++) send_px(i + 1, i == 0);
        chk("c6 pre valid", WW'(out_valid), WW'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("c6 async valid", WW'(out_valid), '0);
        chk("c6 async win", out_win, '0);
        chk("c6 async last", WW'(out_last), '0);
        @(posedge clk);
        #3;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        q_win.delete(); q_last.delete();
        send_frame(0);
        drain();
        chk_count("c6", NWIN);
        check_frame(0, 0, "c6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
